// File: rtl/top_module_pkg.sv
// Shared defaults and helpers for the top_module_core AND-monitor cell.
package top_module_pkg;

  localparam int unsigned CNT_W_DEF      = 8;
  localparam int unsigned STABLE_LEN_DEF = 4;

  // Bits needed to hold values 0..n, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w > 1) ? w : 1;
  endfunction

endpackage

// File: rtl/top_module_core_sat_counter.sv
// Saturating up-counter: rst > clr > inc, holds at all-ones.
module sat_counter
  import top_module_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         at_max
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  assign q      = q_q;
  assign at_max = &q_q;

  // Next count: clear wins over increment, increment stops at all-ones.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && !at_max) begin
      q_d = q_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/top_module_core.sv
// 3-input AND with clocked monitoring: registered copy, edge pulses,
// held-high flag and saturating high-cycle count.
module top_module_core
  import top_module_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned STABLE_LEN = STABLE_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             out,
  output logic             out_q,
  output logic             out_rise,
  output logic             out_fall,
  output logic             out_stable,
  output logic [CNT_W-1:0] hi_cnt,
  output logic             cnt_sat
);

  localparam int unsigned      RUN_W   = clog2_min1(STABLE_LEN);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_LEN);

  logic             out_q_q, out_q_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [RUN_W-1:0] run_cnt;
  logic             run_at_max;
  logic             run_full;

  assign out        = a & b & c;
  assign out_q      = out_q_q;
  assign out_rise   = rise_q;
  assign out_fall   = fall_q;
  assign out_stable = (run_cnt == RUN_MAX);

  // Next registered value and edge pulses relative to the current out_q.
  always_comb begin
    out_q_d = out;
    rise_d  = out & ~out_q_q;
    fall_d  = ~out & out_q_q;
  end

  // Registered copy and pulse flops, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      out_q_q <= out_q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_hi_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (1'b0),
    .inc    (out_q_q),
    .q      (hi_cnt),
    .at_max (cnt_sat)
  );

  // The run counter's own ceiling is all-ones; stop it at STABLE_LEN instead.
  // at_max only fires when STABLE_LEN itself is all-ones, so OR-ing it is exact.
  assign run_full = run_at_max | (run_cnt == RUN_MAX);

  sat_counter #(.W(RUN_W)) u_run_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (~out_q_q),
    .inc    (out_q_q & ~run_full),
    .q      (run_cnt),
    .at_max (run_at_max)
  );

endmodule

// File: tb/tb_top_module_core.sv
// Bench for top_module_core: directed scenarios plus random traffic,
// checked against a history-based reference model.
module tb_top_module_core;

  localparam int unsigned CNT_W      = 3;
  localparam int unsigned STABLE_LEN = 4;
  localparam int unsigned HI_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             a = 1'b0, b = 1'b0, c = 1'b0;
  logic             out, out_q, out_rise, out_fall, out_stable, cnt_sat;
  logic [CNT_W-1:0] hi_cnt;

  int total = 0;
  int bad   = 0;

  // out value sampled at every non-reset edge since the last reset edge
  bit hist[$];

  top_module_core #(.CNT_W(CNT_W), .STABLE_LEN(STABLE_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .c          (c),
    .out        (out),
    .out_q      (out_q),
    .out_rise   (out_rise),
    .out_fall   (out_fall),
    .out_stable (out_stable),
    .hi_cnt     (hi_cnt),
    .cnt_sat    (cnt_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Derive every expected output from the sampled history.
  task automatic check_model();
    int    n;
    bit    cur, prev;
    int    ones;
    int    run;
    n    = hist.size();
    cur  = (n >= 1) ? hist[n-1] : 1'b0;
    prev = (n >= 2) ? hist[n-2] : 1'b0;
    ones = 0;
    for (int i = 0; i < n - 1; i++) ones += hist[i];
    run = 0;
    for (int i = n - 2; i >= 0; i--) begin
      if (!hist[i]) break;
      run++;
    end
    check("out",        32'(out),        32'(a & b & c));
    check("out_q",      32'(out_q),      32'(cur));
    check("out_rise",   32'(out_rise),   32'((n >= 1) && cur && !prev));
    check("out_fall",   32'(out_fall),   32'((n >= 1) && !cur && prev));
    check("out_stable", 32'(out_stable), 32'(run >= STABLE_LEN));
    check("hi_cnt",     32'(hi_cnt),     32'((ones > HI_MAX) ? HI_MAX : ones));
    check("cnt_sat",    32'(cnt_sat),    32'(ones >= HI_MAX));
  endtask

  // One clock: update the model at the edge, then check 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (rst) hist.delete();
    else     hist.push_back(a & b & c);
    #1;
    check_model();
  endtask

  task automatic drive(input logic [2:0] abc, input logic r);
    {a, b, c} = abc;
    rst       = r;
  endtask

  task automatic run_n(input logic [2:0] abc, input int n);
    drive(abc, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Combinational sweep, no clock edge involved.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {a, b, c} = v;
      #1;
      check("comb", 32'(out), 32'(v == 3'b111));
    end

    // Reset held two clocks with abc=111.
    @(negedge clk);
    drive(3'b111, 1'b1);
    tick();
    tick();
    check("rst_out", 32'(out), 32'd1);
    check("rst_hi",  32'(hi_cnt), 32'd0);

    // Edge pulses: 000 -> 111 x3 -> 011.
    run_n(3'b000, 1);
    run_n(3'b111, 3);
    run_n(3'b011, 3);

    // Stable flag: hold high, one-cycle drop, recover.
    run_n(3'b111, 6);
    check("stable_on", 32'(out_stable), 32'd1);
    run_n(3'b110, 1);
    run_n(3'b111, 2);
    check("stable_off", 32'(out_stable), 32'd0);

    // Saturation from a fresh reset.
    drive(3'b111, 1'b1);
    tick();
    run_n(3'b111, 10);
    check("sat_hi",  32'(hi_cnt),  32'(HI_MAX));
    check("sat_flag", 32'(cnt_sat), 32'd1);

    // Mid-run reset at hi_cnt=5.
    drive(3'b111, 1'b1);
    tick();
    drive(3'b111, 1'b0);
    for (int i = 0; i < 20 && hi_cnt != 3'd5; i++) tick();
    check("mid_hi5", 32'(hi_cnt), 32'd5);
    drive(3'b111, 1'b1);
    tick();
    check("mid_clr", 32'(hi_cnt), 32'd0);
    run_n(3'b111, 3);
    check("mid_resume", 32'(hi_cnt), 32'd2);

    // Random traffic biased toward 111, with occasional resets.
    for (int i = 0; i < 300; i++) begin
      logic [2:0] v;
      v = ($urandom_range(0, 2) != 0) ? 3'b111 : 3'($urandom_range(0, 7));
      drive(v, ($urandom_range(0, 39) == 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
